// File: rtl/tinyjambu_perm_seq_if.sv
// Request/response bundle between a host and the TinyJAMBU permutation sequencer.
interface tinyjambu_perm_seq_if #(
    parameter int unsigned CW = 6
);
    logic           req_valid;
    logic           req_ready;
    logic [127:0]   req_state;
    logic [127:0]   req_key;
    logic [CW-1:0]  req_nblk;
    logic           flush;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [127:0]   rsp_state;
    logic           busy;

    modport master (
        output req_valid, req_state, req_key, req_nblk, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_state, busy
    );

    modport slave (
        input  req_valid, req_state, req_key, req_nblk, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_state, busy
    );
endinterface

// File: rtl/tinyjambu_perm_seq.sv
// TinyJAMBU keyed-permutation sequencer: one 32-step block per RUN cycle.
// Define TINYJAMBU_PERM_SEQ_UNROLL2_EN to chain two blocks per RUN cycle.
module tinyjambu_perm_seq #(
    parameter int unsigned MAX_BLK = 32,
    parameter int unsigned CW      = 6
) (
    input logic                 g_clk,
    input logic                 g_resetn,
    tinyjambu_perm_seq_if.slave bus
);
    localparam logic [CW-1:0] MaxBlk = CW'(MAX_BLK);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         r_st;
    logic [127:0]   r_s;
    logic [127:0]   r_key;
    logic [CW-1:0]  r_nblk;
    logic [CW-1:0]  r_idx;
    logic           r_req_ready;
    logic           r_rsp_valid;
    logic           r_busy;

    logic [CW-1:0]  w_nblk;
    logic [31:0]    w_kw0;
    logic [127:0]   w_s1;
    logic [127:0]   w_next_s;
    logic [CW:0]    w_step;
    logic [CW:0]    w_idx_nx;
    logic           w_last;

    // One 32-step block: shift words down, new top word is the NLFSR feedback.
    function automatic logic [127:0] f_blk(input logic [127:0] s, input logic [31:0] kw);
        logic [63:0] w21;
        logic [63:0] w32;
        logic [31:0] t1, t2, t3, t4, fb;
        w21 = s[95:32];
        w32 = s[127:64];
        t1  = w21[46:15];
        t2  = w32[37:6];
        t3  = w32[52:21];
        t4  = w32[58:27];
        fb  = s[31:0] ^ t1 ^ ~(t2 & t3) ^ t4 ^ kw;
        return {fb, s[127:32]};
    endfunction

    assign w_nblk = (bus.req_nblk > MaxBlk) ? MaxBlk : bus.req_nblk;
    assign w_kw0  = r_key[{r_idx[1:0], 5'd0} +: 32];
    assign w_s1   = f_blk(r_s, w_kw0);

`ifdef TINYJAMBU_PERM_SEQ_UNROLL2_EN
    logic [CW-1:0]  w_idx1;
    logic [31:0]    w_kw1;
    logic [127:0]   w_s2;
    logic [CW-1:0]  w_rem;
    logic           w_two;

    assign w_idx1   = r_idx + CW'(1);
    assign w_kw1    = r_key[{w_idx1[1:0], 5'd0} +: 32];
    assign w_s2     = f_blk(w_s1, w_kw1);
    assign w_rem    = r_nblk - r_idx;
    assign w_two    = |w_rem[CW-1:1];
    assign w_next_s = w_two ? w_s2 : w_s1;
    assign w_step   = w_two ? (CW+1)'(2) : (CW+1)'(1);
`else
    assign w_next_s = w_s1;
    assign w_step   = (CW+1)'(1);
`endif

    assign w_idx_nx = {1'b0, r_idx} + w_step;
    assign w_last   = (w_idx_nx >= {1'b0, r_nblk});

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_st        <= StIdle;
            r_s         <= '0;
            r_key       <= '0;
            r_nblk      <= '0;
            r_idx       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_st)
                StIdle: begin
                    if (bus.req_valid && !bus.flush) begin
                        r_s         <= bus.req_state;
                        r_key       <= bus.req_key;
                        r_nblk      <= w_nblk;
                        r_idx       <= '0;
                        r_req_ready <= 1'b0;
                        if (w_nblk == '0) begin
                            r_st        <= StDone;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_st   <= StRun;
                            r_busy <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (bus.flush) begin
                        r_st        <= StIdle;
                        r_s         <= '0;
                        r_key       <= '0;
                        r_idx       <= '0;
                        r_busy      <= 1'b0;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_s   <= w_next_s;
                        r_idx <= w_idx_nx[CW-1:0];
                        if (w_last) begin
                            r_st        <= StDone;
                            r_busy      <= 1'b0;
                            r_rsp_valid <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (bus.flush) begin
                        r_st        <= StIdle;
                        r_s         <= '0;
                        r_key       <= '0;
                        r_idx       <= '0;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        r_st        <= StIdle;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_st        <= StIdle;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Flush in IDLE blocks acceptance; result bus is zero unless a response is presented.
    assign bus.req_ready = r_req_ready & ~bus.flush;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_state = r_rsp_valid ? r_s : '0;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_tinyjambu_perm_seq.sv
// Directed self-checking bench for tinyjambu_perm_seq (either build of the unroll option).
module tb_tinyjambu_perm_seq;
    localparam int CW = 6;

    logic g_clk;
    logic g_resetn;
    int   errors;
    int   checks;
    int   rsp_cnt;
    int   busy_cnt;
    logic rsp_prev;

    tinyjambu_perm_seq_if #(.CW(CW)) bus ();

    tinyjambu_perm_seq #(
        .MAX_BLK (32),
        .CW      (CW)
    ) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (bus)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    always @(negedge g_clk) begin
        if (bus.rsp_valid && !rsp_prev) rsp_cnt++;
        rsp_prev = bus.rsp_valid;
        if (bus.busy) busy_cnt++;
    end

    function automatic int exp_lat(input int n);
`ifdef TINYJAMBU_PERM_SEQ_UNROLL2_EN
        return (n + 1) / 2 + 1;
`else
        return n + 1;
`endif
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key,
                                           input int n);
        logic [31:0] s0, s1, s2, s3, k, t1, t2, t3, t4, fb;
        logic [63:0] a, b;
        s0 = st[31:0];
        s1 = st[63:32];
        s2 = st[95:64];
        s3 = st[127:96];
        for (int i = 0; i < n; i++) begin
            k  = 32'(key >> (32 * (i % 4)));
            a  = {s2, s1};
            b  = {s3, s2};
            t1 = 32'(a >> 15);
            t2 = 32'(b >> 6);
            t3 = 32'(b >> 21);
            t4 = 32'(b >> 27);
            fb = s0 ^ t1 ^ ~(t2 & t3) ^ t4 ^ k;
            s0 = s1;
            s1 = s2;
            s2 = s3;
            s3 = fb;
        end
        return {s3, s2, s1, s0};
    endfunction

    // Called at a negedge with the sequencer idle; returns at a negedge after the handshake.
    task automatic run_req(input logic [127:0] st, input logic [127:0] key,
                           input logic [CW-1:0] nblk, input int stall, output int lat,
                           output logic [127:0] res, output bit stable, output bit ok);
        ok     = 1'b1;
        stable = 1'b1;
        res    = '0;
        bus.req_valid = 1'b1;
        bus.req_state = st;
        bus.req_key   = key;
        bus.req_nblk  = nblk;
        @(posedge g_clk);
        @(negedge g_clk);
        bus.req_valid = 1'b0;
        bus.req_state = ~st;
        bus.req_key   = ~key;
        bus.req_nblk  = 6'd3;
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin
            @(posedge g_clk);
            @(negedge g_clk);
            lat++;
        end
        if (!bus.rsp_valid) begin
            ok = 1'b0;
            return;
        end
        res = bus.rsp_state;
        for (int i = 0; i < stall; i++) begin
            @(posedge g_clk);
            @(negedge g_clk);
            if (!bus.rsp_valid || bus.rsp_state !== res) stable = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge g_clk);
        @(negedge g_clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.req_ready !== 1'b1) begin errors++;
            $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++;
            $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.rsp_state !== 128'h0) begin errors++;
            $display("FAIL reset_rsp_state: got %h want 0", bus.rsp_state); end
    endtask

    task automatic test_single_block();
        int lat; logic [127:0] res; bit st, ok;
        run_req(128'h0, 128'h0, 6'd1, 0, lat, res, st, ok);
        checks++; if (!ok) begin errors++; $display("FAIL one_blk_timeout: no rsp_valid"); end
        checks++; if (lat !== 2) begin errors++;
            $display("FAIL one_blk_latency: got %0d want 2", lat); end
        checks++; if (res !== 128'hFFFFFFFF_00000000_00000000_00000000) begin errors++;
            $display("FAIL one_blk_state: got %h want ffffffff000...", res); end
        checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++;
            $display("FAIL one_blk_after_hs: got rdy=%b vld=%b want 1/0",
                     bus.req_ready, bus.rsp_valid); end
    endtask

    task automatic test_two_block();
        int lat; logic [127:0] res; bit st, ok;
        run_req(128'h0, 128'h0, 6'd2, 0, lat, res, st, ok);
        checks++; if (lat !== exp_lat(2)) begin errors++;
            $display("FAIL two_blk_latency: got %0d want %0d", lat, exp_lat(2)); end
        checks++; if (res !== 128'hFC00001F_FFFFFFFF_00000000_00000000) begin errors++;
            $display("FAIL two_blk_state: got %h want fc00001fffffffff0000000000000000", res); end
    endtask

    task automatic test_zero_blocks();
        int lat; logic [127:0] res; bit st, ok;
        logic [127:0] s;
        s = 128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978;
        busy_cnt = 0;
        run_req(128'h0, 128'h5, 6'd0, 0, lat, res, st, ok);
        checks++; if (lat !== 1) begin errors++;
            $display("FAIL zero_blk_latency: got %0d want 1", lat); end
        checks++; if (res !== 128'h0) begin errors++;
            $display("FAIL zero_blk_state: got %h want 0", res); end
        run_req(s, 128'h5, 6'd0, 0, lat, res, st, ok);
        checks++; if (res !== s) begin errors++;
            $display("FAIL zero_blk_passthru: got %h want %h", res, s); end
        checks++; if (busy_cnt !== 0) begin errors++;
            $display("FAIL zero_blk_busy: got %0d busy cycles want 0", busy_cnt); end
    endtask

    task automatic test_key();
        int lat; logic [127:0] res, k; bit st, ok;
        k = 128'h00000000_00000000_00000000_00000001;
        run_req(128'h0, k, 6'd1, 0, lat, res, st, ok);
        checks++; if (res !== 128'hFFFFFFFE_00000000_00000000_00000000) begin errors++;
            $display("FAIL key_one_blk: got %h want fffffffe000...", res); end
        run_req(128'h0, k, 6'd5, 0, lat, res, st, ok);
        checks++; if (res !== model(128'h0, k, 5)) begin errors++;
            $display("FAIL key_wrap: got %h want %h", res, model(128'h0, k, 5)); end
        checks++; if (lat !== exp_lat(5)) begin errors++;
            $display("FAIL key_wrap_latency: got %0d want %0d", lat, exp_lat(5)); end
    endtask

    task automatic test_stall();
        int lat; logic [127:0] res, s, k; bit st, ok;
        int nb[2];
        nb[0] = 20;
        nb[1] = 32;
        s = 128'h3C6EF372_A54FF53A_510E527F_9B05688C;
        k = 128'h1F83D9AB_5BE0CD19_CBBB9D5D_629A292A;
        for (int i = 0; i < 2; i++) begin
            rsp_cnt = 0;
            run_req(s, k, CW'(nb[i]), 5, lat, res, st, ok);
            repeat (4) @(negedge g_clk);
            checks++; if (res !== model(s, k, nb[i])) begin errors++;
                $display("FAIL stall_state_%0d: got %h want %h", nb[i], res, model(s, k, nb[i]));
            end
            checks++; if (!st) begin errors++;
                $display("FAIL stall_stable_%0d: got unstable want stable", nb[i]); end
            checks++; if (lat !== exp_lat(nb[i])) begin errors++;
                $display("FAIL stall_latency_%0d: got %0d want %0d", nb[i], lat, exp_lat(nb[i]));
            end
            checks++; if (rsp_cnt !== 1) begin errors++;
                $display("FAIL stall_rsp_count_%0d: got %0d want 1", nb[i], rsp_cnt); end
            s = res;
        end
    endtask

    task automatic test_clamp();
        int lat; logic [127:0] res, s, k; bit st, ok;
        s = 128'hDEADBEEF_CAFEF00D_01020304_A5A5A5A5;
        k = 128'h00010203_04050607_08090A0B_0C0D0E0F;
        run_req(s, k, 6'd40, 0, lat, res, st, ok);
        checks++; if (res !== model(s, k, 32)) begin errors++;
            $display("FAIL clamp_state: got %h want %h", res, model(s, k, 32)); end
        checks++; if (lat !== exp_lat(32)) begin errors++;
            $display("FAIL clamp_latency: got %0d want %0d", lat, exp_lat(32)); end
    endtask

    task automatic test_flush_run();
        int lat; logic [127:0] res; bit st, ok;
        rsp_cnt = 0;
        bus.req_valid = 1'b1;
        bus.req_state = 128'h11112222_33334444_55556666_77778888;
        bus.req_key   = 128'h99990000_AAAABBBB_CCCCDDDD_EEEEFFFF;
        bus.req_nblk  = 6'd32;
        @(posedge g_clk);
        @(negedge g_clk);
        bus.req_valid = 1'b0;
        repeat (2) begin
            @(posedge g_clk);
            @(negedge g_clk);
        end
        bus.flush = 1'b1;
        @(posedge g_clk);
        @(negedge g_clk);
        bus.flush = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++;
            $display("FAIL flush_run_outputs: got busy=%b vld=%b want 0/0",
                     bus.busy, bus.rsp_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++;
            $display("FAIL flush_run_ready: got %b want 1", bus.req_ready); end
        repeat (40) @(negedge g_clk);
        checks++; if (rsp_cnt !== 0) begin errors++;
            $display("FAIL flush_run_no_rsp: got %0d responses want 0", rsp_cnt); end
        run_req(128'h0, 128'h0, 6'd0, 0, lat, res, st, ok);
        checks++; if (res !== 128'h0 || lat !== 1) begin errors++;
            $display("FAIL flush_run_next: got %h lat %0d want 0 lat 1", res, lat); end
    endtask

    task automatic test_flush_idle();
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_state = 128'h1234;
        bus.req_nblk  = 6'd0;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++;
            $display("FAIL flush_idle_ready: got %b want 0", bus.req_ready); end
        @(posedge g_clk);
        @(negedge g_clk);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++;
            $display("FAIL flush_idle_not_accepted: got vld=%b rdy=%b want 0/1",
                     bus.rsp_valid, bus.req_ready); end
        @(negedge g_clk);
    endtask

    task automatic test_async_reset();
        int lat; logic [127:0] res; bit st, ok;
        rsp_cnt = 0;
        bus.req_valid = 1'b1;
        bus.req_state = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
        bus.req_key   = 128'h0;
        bus.req_nblk  = 6'd32;
        @(posedge g_clk);
        @(negedge g_clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge g_clk);
        #2 g_resetn = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
                      bus.rsp_state !== 128'h0) begin errors++;
            $display("FAIL async_reset_outputs: got busy=%b vld=%b rdy=%b st=%h want 0/0/1/0",
                     bus.busy, bus.rsp_valid, bus.req_ready, bus.rsp_state); end
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(negedge g_clk);
        run_req(128'h0, 128'h0, 6'd2, 0, lat, res, st, ok);
        checks++; if (res !== 128'hFC00001F_FFFFFFFF_00000000_00000000) begin errors++;
            $display("FAIL async_reset_next: got %h want fc00001fffffffff0000000000000000", res);
        end
        checks++; if (rsp_cnt !== 1) begin errors++;
            $display("FAIL async_reset_rsp_count: got %0d want 1", rsp_cnt); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [127:0] res; bit st, ok;
        run_req(128'h0, 128'h0, 6'd1, 0, lat, res, st, ok);
        checks++; if (bus.req_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_ready: got %b want 1", bus.req_ready); end
        run_req(128'h0, 128'h0, 6'd2, 0, lat, res, st, ok);
        checks++; if (res !== 128'hFC00001F_FFFFFFFF_00000000_00000000 || !ok) begin errors++;
            $display("FAIL b2b_second: got %h want fc00001fffffffff0000000000000000", res); end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rsp_cnt       = 0;
        busy_cnt      = 0;
        rsp_prev      = 1'b0;
        g_resetn      = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_state = '0;
        bus.req_key   = '0;
        bus.req_nblk  = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge g_clk);
        test_reset();
        g_resetn = 1'b1;
        @(negedge g_clk);
        test_reset();
        test_single_block();
        test_two_block();
        test_zero_blocks();
        test_key();
        test_stall();
        test_clamp();
        test_flush_run();
        test_flush_idle();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
